kmc_intr_ctrl: RTL

- Interrupt sequencer for the KMC11 microprocessor.
- Accepts the one-cycle interrupt trigger and vector-select bit produced by the MISC register and queues up to two requests.
- Presents a level interrupt request to the bus interrupt arbiter and answers each acknowledge with the selected vector.
- Drives the IRQO status bit back into MISC bit 7.

---
 rtl/kmc_intr_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/kmc_intr_ctrl.sv
// KMC11 interrupt sequencer: queues MISC-triggered requests, raises devINTR to the
// bus arbiter and answers each acknowledge with a one-cycle vector strobe.
module kmc_intr_ctrl #(
    parameter logic [15:0] VECT = 16'o000540,
    parameter int          GAP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kmcINIT,
    input  logic        kmcSETIRQ,
    input  logic        kmcVECTXXX4,
    input  logic        devINTA,
    output logic        devINTR,
    output logic [15:0] devVECT,
    output logic        devVECTVLD,
    output logic        kmcIRQO,
    output logic        kmcIRQOVF
);

    // state | meaning
    // sIdle | no request outstanding, waiting for a queued entry
    // sReq  | devINTR asserted, waiting for devINTA
    // sVect | vector strobe cycle, head entry popped
    // sWait | enforced devINTR-low gap, gap counter running down
    typedef enum logic [1:0] {sIdle, sReq, sVect, sWait} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP);

    state_t     state;
    logic [1:0] fifo;       // fifo[0] is the oldest entry
    logic [1:0] cnt;
    logic [3:0] gapCnt;

    logic       push;
    logic       pop;
    logic [1:0] fifoNext;
    logic [1:0] cntNext;
    logic       ovfSet;

    assign push = kmcSETIRQ;
    assign pop  = (state == sVect) && (cnt != 2'd0);

    always_comb begin
        fifoNext = fifo;
        cntNext  = cnt;
        ovfSet   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (cnt == 2'd2) begin
                    ovfSet = 1'b1;
                end else begin
                    if (cnt == 2'd0) fifoNext[0] = kmcVECTXXX4;
                    else             fifoNext[1] = kmcVECTXXX4;
                    cntNext = cnt + 2'd1;
                end
            end
            2'b01: begin
                fifoNext[0] = fifo[1];
                cntNext     = cnt - 2'd1;
            end
            2'b11: begin
                // simultaneous push/pop keeps the count; the new entry lands behind any survivor
                if (cnt == 2'd2) begin
                    fifoNext[0] = fifo[1];
                    fifoNext[1] = kmcVECTXXX4;
                end else begin
                    fifoNext[0] = kmcVECTXXX4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= sIdle;
            fifo       <= 2'b00;
            cnt        <= 2'd0;
            gapCnt     <= 4'd0;
            devINTR    <= 1'b0;
            devVECT    <= 16'd0;
            devVECTVLD <= 1'b0;
            kmcIRQO    <= 1'b0;
            kmcIRQOVF  <= 1'b0;
        end else if (kmcINIT) begin
            state      <= sIdle;
            fifo       <= 2'b00;
            cnt        <= 2'd0;
            gapCnt     <= 4'd0;
            devINTR    <= 1'b0;
            devVECT    <= 16'd0;
            devVECTVLD <= 1'b0;
            kmcIRQO    <= 1'b0;
            kmcIRQOVF  <= 1'b0;
        end else begin
            fifo    <= fifoNext;
            cnt     <= cntNext;
            kmcIRQO <= (cntNext != 2'd0);
            if (ovfSet) kmcIRQOVF <= 1'b1;

            case (state)
                sIdle: begin
                    if (cntNext != 2'd0) begin
                        state   <= sReq;
                        devINTR <= 1'b1;
                    end
                end
                sReq: begin
                    if (devINTA) begin
                        state      <= sVect;
                        devINTR    <= 1'b0;
                        devVECTVLD <= 1'b1;
                        devVECT    <= VECT | {13'd0, fifo[0], 2'b00};
                    end
                end
                sVect: begin
                    devVECTVLD <= 1'b0;
                    devVECT    <= 16'd0;
                    gapCnt     <= GAP_LOAD;
                    state      <= sWait;
                end
                sWait: begin
                    gapCnt <= gapCnt - 4'd1;
                    // terminal count folds the idle decision in, so devINTR is low GAP+1 cycles
                    if (gapCnt == 4'd1) begin
                        if (cntNext != 2'd0) begin
                            state   <= sReq;
                            devINTR <= 1'b1;
                        end else begin
                            state <= sIdle;
                        end
                    end
                end
                default: state <= sIdle;
            endcase
        end
    end

endmodule
